// File: rtl/rns_pkg.sv
// rns_pkg: shared widths, default moduli/inverse tables and converter state type.
package rns_pkg;
    localparam int MOD_WID  = 9;
    localparam int RES_WID  = 8;
    localparam int PROD_WID = 17;
    localparam logic [2*MOD_WID-1:0] DEF_MODULI  = {9'd256, 9'd129};
    localparam logic [4*MOD_WID-1:0] DEF_MRC_INV = {9'd0, 9'd129, 9'd0, 9'd0};
    typedef enum logic [2:0] {IDLE, SUB, REDUCE, HORNER, DONE} state_t;
    // Bit offset of inverse(m_j) mod m_i in the packed MRC_INV table.
    function automatic int inv_idx(input int i, input int j, input int n);
        return (i * n + j) * MOD_WID;
    endfunction
endpackage

// File: rtl/rns_mod_reduce.sv
// rns_mod_reduce: sequential shift-subtract reduction of p < m*256 to p mod m in 8 steps.
module rns_mod_reduce
    import rns_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [PROD_WID-1:0] i_p,
    input  logic [MOD_WID-1:0]  i_m,
    output logic                o_done,
    output logic [MOD_WID-1:0]  o_rem
);
    logic [PROD_WID-1:0] r_p;
    logic [MOD_WID-1:0]  r_m;
    logic [2:0]          r_k;
    logic                r_busy;
    logic [PROD_WID-1:0] w_shm;
    logic [PROD_WID-1:0] w_p_next;

    assign w_shm    = PROD_WID'(r_m) << r_k;
    assign w_p_next = (r_p >= w_shm) ? r_p - w_shm : r_p;
    // Done is asserted during the final step so the caller can take o_rem on that edge.
    assign o_done   = r_busy && (r_k == 3'd0);
    assign o_rem    = w_p_next[MOD_WID-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p    <= '0;
            r_m    <= '0;
            r_k    <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_p    <= i_p;
            r_m    <= i_m;
            r_k    <= 3'd7;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_p    <= w_p_next;
            r_k    <= r_k - 3'd1;
            r_busy <= (r_k != 3'd0);
        end
    end
endmodule

// File: rtl/rns_reverse_converter.sv
// rns_reverse_converter: RNS residues to binary via mixed-radix conversion and Horner accumulation.
module rns_reverse_converter
    import rns_pkg::*;
#(
    parameter int NUM_DOMAINS = 2,
    parameter logic [NUM_DOMAINS*MOD_WID-1:0] MODULI = DEF_MODULI,
    parameter logic [NUM_DOMAINS*NUM_DOMAINS*MOD_WID-1:0] MRC_INV = DEF_MRC_INV,
    parameter int OUT_WID = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_DOMAINS*RES_WID-1:0] residues_in,
    input  logic [3:0]                     dest_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_WID-1:0]             result,
    output logic                           range_err,
    output logic [3:0]                     dest_out,
    output logic                           busy
);
    localparam int IW = $clog2(NUM_DOMAINS);

    state_t                         r_state;
    logic [IW-1:0]                  r_i, r_j, r_hidx;
    logic [MOD_WID-1:0]             r_t;
    logic [MOD_WID-1:0]             r_v [NUM_DOMAINS];
    logic [NUM_DOMAINS*RES_WID-1:0] r_res;
    logic [OUT_WID-1:0]             r_x;

    logic [MOD_WID-1:0]  w_m_i, w_v_j, w_inv, w_d, w_m_h, w_rem;
    logic [MOD_WID:0]    w_diff;
    logic [PROD_WID-1:0] w_p;
    logic [OUT_WID-1:0]  w_x_next;
    logic                w_bad, w_done;

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state == SUB) || (r_state == REDUCE) || (r_state == HORNER);
    assign w_m_i    = MODULI[int'(r_i)*MOD_WID +: MOD_WID];
    assign w_v_j    = r_v[r_j];
    assign w_inv    = MRC_INV[inv_idx(int'(r_i), int'(r_j), NUM_DOMAINS) +: MOD_WID];
    // Sign bit of the 10-bit difference selects the wrap by m_i; m_i=256 needs the extra bit.
    assign w_diff   = {1'b0, r_t} - {1'b0, w_v_j};
    assign w_d      = w_diff[MOD_WID] ? MOD_WID'(w_diff + {1'b0, w_m_i}) : w_diff[MOD_WID-1:0];
    assign w_p      = PROD_WID'(w_d) * PROD_WID'(w_inv);
    assign w_m_h    = MODULI[int'(r_hidx)*MOD_WID +: MOD_WID];
    assign w_x_next = r_x * OUT_WID'(w_m_h) + OUT_WID'(r_v[r_hidx]);

    always_comb begin
        w_bad = 1'b0;
        for (int n = 0; n < NUM_DOMAINS; n++)
            w_bad = w_bad | ({1'b0, residues_in[n*RES_WID +: RES_WID]} >= MODULI[n*MOD_WID +: MOD_WID]);
    end

    rns_mod_reduce u_reduce (
        .clk    (clk),
        .reset  (reset),
        .i_load (r_state == SUB),
        .i_p    (w_p),
        .i_m    (w_m_i),
        .o_done (w_done),
        .o_rem  (w_rem)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_i       <= '0;
            r_j       <= '0;
            r_hidx    <= '0;
            r_t       <= '0;
            r_res     <= '0;
            r_x       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            range_err <= 1'b0;
            dest_out  <= '0;
            for (int n = 0; n < NUM_DOMAINS; n++) r_v[n] <= '0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_res     <= residues_in;
                    dest_out  <= dest_in;
                    r_v[0]    <= MOD_WID'(residues_in[RES_WID-1:0]);
                    r_t       <= MOD_WID'(residues_in[RES_WID +: RES_WID]);
                    r_i       <= IW'(1);
                    r_j       <= '0;
                    result    <= '0;
                    range_err <= w_bad;
                    out_valid <= w_bad;
                    r_state   <= w_bad ? DONE : SUB;
                end
                SUB: r_state <= REDUCE;
                REDUCE: if (w_done) begin
                    if (int'(r_j) + 1 < int'(r_i)) begin
                        r_j     <= r_j + 1'b1;
                        r_t     <= w_rem;
                        r_state <= SUB;
                    end else begin
                        r_v[r_i] <= w_rem;
                        if (int'(r_i) + 1 < NUM_DOMAINS) begin
                            r_i     <= r_i + 1'b1;
                            r_j     <= '0;
                            r_t     <= MOD_WID'(r_res[(int'(r_i)+1)*RES_WID +: RES_WID]);
                            r_state <= SUB;
                        end else begin
                            r_x     <= OUT_WID'(w_rem);
                            r_hidx  <= IW'(NUM_DOMAINS - 2);
                            r_state <= HORNER;
                        end
                    end
                end
                HORNER: begin
                    r_x <= w_x_next;
                    if (r_hidx == '0) begin
                        result    <= w_x_next;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_hidx <= r_hidx - 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rns_reverse_converter.sv
// tb_rns_reverse_converter: randomized and directed checks against a brute-force CRT model.
module tb_rns_reverse_converter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] residues_in = '0;
    logic [3:0]  dest_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        range_err;
    logic [3:0]  dest_out;
    logic        busy;
    int          total = 0;
    int          bad = 0;

    rns_reverse_converter dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .residues_in (residues_in),
        .dest_in     (dest_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .range_err   (range_err),
        .dest_out    (dest_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // The unique X below 129*256 with X mod 129 == r0 and X mod 256 == r1.
    function automatic int ref_x(input int r0, input int r1);
        for (int x = 0; x < 129 * 256; x++)
            if (x % 129 == r0 && x % 256 == r1) return x;
        return -1;
    endfunction

    task automatic run(input logic [7:0] r1, input logic [7:0] r0, input logic [3:0] d, input int hold);
        int          lat, n, x_e;
        logic        err_e, ok;
        logic [15:0] res0;
        logic [3:0]  d0;
        err_e = (r0 >= 8'd129);
        x_e   = err_e ? 0 : ref_x(int'(r0), int'(r1));
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready", in_ready, 1);
        residues_in = {r1, r0};
        dest_in     = d;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (err_e) check("err_latency", lat <= 1, 1);
        else check("latency", lat, 10);
        check("result", result, x_e);
        check("range_err", range_err, err_e);
        check("dest_out", dest_out, d);
        ok   = 1'b1;
        res0 = result;
        d0   = dest_out;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            ok &= out_valid && !in_ready && !busy && result == res0 && dest_out == d0 && range_err == err_e;
        end
        check("hold", ok, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic ok;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {out_valid, busy, range_err, dest_out, result}, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        residues_in = {8'd232, 8'd97};
        dest_in     = 4'b0110;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("abort_clear", {out_valid, busy, result}, 0);
        check("abort_ready", in_ready, 1);
        #2 reset = 1'b1;
        ok = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            ok &= !out_valid && in_ready && !busy;
        end
        check("no_stale", ok, 1);
        run(8'd232, 8'd97, 4'b1010, 0);
        run(8'd0, 8'd127, 4'b0011, 1);
        run(8'd0, 8'd0, 4'b0000, 0);
        run(8'd255, 8'd128, 4'b1111, 2);
        run(8'd5, 8'd200, 4'b0101, 3);
        run(8'd232, 8'd97, 4'b1100, 20);
        run(8'd255, 8'd128, 4'b1001, 0);
        for (int k = 0; k < 25; k++)
            run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 150)),
                4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
